// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter. It also launches the stored bytes
// one at a time.
//
// Host logic pushes bytes at up to one per clock. Whenever the FIFO is not empty and the
// launcher is idle, the launcher pops the head byte and pulses o_Tx_DV for one cycle. It then
// follows the transmitter through Active -> Done -> Done low before launching the next byte.
//
// Ports:
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Wr_DV      write strobe, one byte per high cycle
//   i_Wr_Byte    byte to enqueue
//   o_Full       FIFO holds DEPTH bytes
//   o_Empty      FIFO holds no bytes
//   o_Count      occupancy, 0..DEPTH
//   o_Overflow   sticky: a write was dropped while full
//   o_Tx_DV      one-cycle launch strobe to the transmitter
//   o_Tx_Byte    byte for the transmitter, held until the next launch
//   i_Tx_Active  transmitter busy
//   i_Tx_Done    transmitter finished a frame
module uart_tx_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              i_Clock,
   input  logic              i_Reset,
   input  logic              i_Wr_DV,
   input  logic [7:0]        i_Wr_Byte,
   output logic              o_Full,
   output logic              o_Empty,
   output logic [ADDR_W:0]   o_Count,
   output logic              o_Overflow,
   output logic              o_Tx_DV,
   output logic [7:0]        o_Tx_Byte,
   input  logic              i_Tx_Active,
   input  logic              i_Tx_Done
);

   typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone, StGap} state_t;

   localparam logic [ADDR_W:0]   FullCount = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CountOne  = 1;
   localparam logic [ADDR_W-1:0] PtrOne    = 1;

   state_t              state;
   logic [7:0]          mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic                push;
   logic                pop;
   logic [ADDR_W:0]     count_next;

   // A full FIFO refuses the write even if a pop happens on the same edge.
   assign push = i_Wr_DV && !o_Full;
   assign pop  = (state == StIdle) && !o_Empty;

   always_comb begin
      count_next = o_Count;
      if (push && !pop) begin
         count_next = o_Count + CountOne;
      end else if (pop && !push) begin
         count_next = o_Count - CountOne;
      end
   end

   // Storage array, not reset; stale entries are unreachable once the pointers are cleared.
   always_ff @(posedge i_Clock) begin
      if (!i_Reset && push) begin
         mem[wr_ptr] <= i_Wr_Byte;
      end
   end

   // Pointers, occupancy and status flags. The flags come from count_next, so they
   // describe the state after this edge.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_Count    <= '0;
         o_Full     <= 1'b0;
         o_Empty    <= 1'b1;
         o_Overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PtrOne;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PtrOne;
         end
         if (i_Wr_DV && o_Full) begin
            o_Overflow <= 1'b1;
         end
         o_Count <= count_next;
         o_Full  <= (count_next == FullCount);
         o_Empty <= (count_next == '0);
      end
   end

   // Launch controller. Pop and launch happen together on leaving StIdle.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state     <= StIdle;
         o_Tx_DV   <= 1'b0;
         o_Tx_Byte <= 8'h00;
      end else begin
         case (state)
            StIdle: begin
               o_Tx_DV <= 1'b0;
               if (!o_Empty) begin
                  o_Tx_Byte <= mem[rd_ptr];
                  o_Tx_DV   <= 1'b1;
                  state     <= StWaitBusy;
               end
            end
            StWaitBusy: begin
               o_Tx_DV <= 1'b0;
               if (i_Tx_Active) begin
                  state <= StWaitDone;
               end
            end
            StWaitDone: begin
               o_Tx_DV <= 1'b0;
               if (i_Tx_Done) begin
                  state <= StGap;
               end
            end
            StGap: begin
               // Hold off until Done drops so a long Done pulse cannot swallow the next DV.
               o_Tx_DV <= 1'b0;
               if (!i_Tx_Done) begin
                  state <= StIdle;
               end
            end
            default: begin
               o_Tx_DV <= 1'b0;
               state   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. A small transmitter model with 4 clocks per bit consumes
// the launches. The model can be switched off so the bench can drive Active and Done by hand.
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_dv = 1'b0;
   logic [7:0] wr_byte = 8'h00;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       tx_active;
   logic       tx_done;

   logic       auto_tx = 1'b1;
   logic       man_active = 1'b0;
   logic       man_done = 1'b0;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
      .i_Clock     (clk),
      .i_Reset     (rst),
      .i_Wr_DV     (wr_dv),
      .i_Wr_Byte   (wr_byte),
      .o_Full      (full),
      .o_Empty     (empty),
      .o_Count     (count),
      .o_Overflow  (overflow),
      .o_Tx_DV     (tx_dv),
      .o_Tx_Byte   (tx_byte),
      .i_Tx_Active (tx_active),
      .i_Tx_Done   (tx_done)
   );

   always #5 clk = ~clk;

   // Transmitter model: a 10-bit frame at 4 clocks per bit, then Done for one cycle.
   logic       m_busy = 1'b0;
   logic       m_active = 1'b0;
   logic       m_done = 1'b0;
   logic [5:0] m_cnt = '0;
   logic [9:0] m_frame = '1;
   logic [9:0] cap = '0;
   logic       serial;
   logic       dv_prev = 1'b0;
   int         frames = 0;
   int         dv_count = 0;
   int         dv_wide = 0;
   logic [7:0] sent [$];

   assign serial    = m_busy ? m_frame[0] : 1'b1;
   assign tx_active = auto_tx ? m_active : man_active;
   assign tx_done   = auto_tx ? m_done : man_done;

   always @(posedge clk) begin
      dv_prev <= tx_dv;
      if (tx_dv) dv_count <= dv_count + 1;
      if (tx_dv && dv_prev) dv_wide <= dv_wide + 1;
      if (!m_busy) begin
         m_done <= 1'b0;
         if (tx_dv && auto_tx) begin
            m_busy   <= 1'b1;
            m_active <= 1'b1;
            m_frame  <= {1'b1, tx_byte, 1'b0};
            m_cnt    <= '0;
            sent.push_back(tx_byte);
         end
      end else begin
         if (m_cnt[1:0] == 2'd2) cap <= {serial, cap[9:1]};
         if (m_cnt[1:0] == 2'd3) m_frame <= {1'b1, m_frame[9:1]};
         if (m_cnt == 6'd39) begin
            m_busy   <= 1'b0;
            m_active <= 1'b0;
            m_done   <= 1'b1;
            frames   <= frames + 1;
         end else begin
            m_cnt <= m_cnt + 6'd1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_frames(input string tag, input int target, input int limit);
      int n;
      n = 0;
      while (frames < target && n < limit) begin
         step();
         n++;
      end
      check(tag, frames, target);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   int base_s;
   int f0;
   int dvs;

   initial begin
      // Reset held two cycles with a write pending.
      rst = 1'b1; wr_dv = 1'b1; wr_byte = 8'hEE;
      steps(2);
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_dv", tx_dv, 0);
      check("rst_byte", tx_byte, 8'h00);
      rst = 1'b0; wr_dv = 1'b0;
      steps(2);
      check("rst_nostore", empty, 1);
      check("rst_nodv", dv_count, 0);

      // Single byte through the transmitter model.
      wr_dv = 1'b1; wr_byte = 8'hA5;
      step();
      wr_dv = 1'b0;
      check("single_empty", empty, 0);
      check("single_count", count, 1);
      check("single_dv_early", tx_dv, 0);
      step();
      check("single_dv", tx_dv, 1);
      check("single_byte", tx_byte, 8'hA5);
      check("single_empty2", empty, 1);
      step();
      check("single_dv_width", tx_dv, 0);
      wait_frames("single_frame_done", 1, 100);
      check("single_serial", cap, {1'b1, 8'hA5, 1'b0});
      steps(3);
      check("single_dv_total", dv_count, 1);
      check("single_dv_wide", dv_wide, 0);
      check("single_hold", tx_byte, 8'hA5);

      // Burst of 20 bytes while the transmitter is busy with the first one.
      for (int i = 0; i < 20; i++) begin
         wr_dv = 1'b1; wr_byte = i[7:0];
         step();
         check("burst_count", count, (i == 0) ? 1 : ((i >= 16) ? 16 : i));
         check("burst_full", full, (i >= 16) ? 1 : 0);
         check("burst_ovf", overflow, (i >= 17) ? 1 : 0);
      end
      wr_dv = 1'b0;
      wait_frames("burst_drain", 18, 1500);
      steps(3);
      check("burst_sent_n", sent.size(), 18);
      for (int j = 0; j < 17; j++) check("burst_order", sent[1 + j], j);
      check("burst_empty", empty, 1);
      check("burst_ovf_sticky", overflow, 1);

      // Wrap-around: three rounds of ten bytes.
      for (int r = 0; r < 3; r++) begin
         base_s = sent.size();
         for (int j = 0; j < 10; j++) begin
            wr_dv = 1'b1; wr_byte = 8'h40 + 8'(r * 16 + j);
            step();
         end
         wr_dv = 1'b0;
         wait_frames("wrap_drain", base_s + 10, 800);
         steps(3);
         check("wrap_count", count, 0);
         for (int j = 0; j < 10; j++) check("wrap_order", sent[base_s + j], 8'h40 + r * 16 + j);
      end

      // Simultaneous push and pop, driving the transmitter handshake by hand.
      auto_tx = 1'b0;
      wr_dv = 1'b1; wr_byte = 8'hB0;
      step();
      wr_dv = 1'b0;
      step();
      check("pp_launch_b0", tx_byte, 8'hB0);
      for (int j = 1; j <= 5; j++) begin
         wr_dv = 1'b1; wr_byte = 8'hB0 + 8'(j);
         step();
      end
      wr_dv = 1'b0;
      steps(3);
      check("stall_count", count, 5);
      check("stall_dv", tx_dv, 0);
      man_active = 1'b1; step();
      man_active = 1'b0; man_done = 1'b1; step();
      man_done = 1'b0; step();
      check("pp_idle_dv", tx_dv, 0);
      check("pp_idle_count", count, 5);
      wr_dv = 1'b1; wr_byte = 8'hB6;
      step();
      wr_dv = 1'b0;
      check("pp_count", count, 5);
      check("pp_dv", tx_dv, 1);
      check("pp_byte", tx_byte, 8'hB1);

      // Reset during the data bits of 8'h3C with four bytes queued.
      rst = 1'b1; step();
      rst = 1'b0; auto_tx = 1'b1;
      f0 = frames;
      base_s = sent.size();
      wr_dv = 1'b1; wr_byte = 8'h3C; step();
      wr_byte = 8'h61; step();
      wr_byte = 8'h62; step();
      wr_byte = 8'h63; step();
      wr_byte = 8'h64; step();
      wr_dv = 1'b0;
      check("mid_queued", count, 4);
      steps(12);
      rst = 1'b1; step();
      rst = 1'b0;
      check("mid_count", count, 0);
      check("mid_empty", empty, 1);
      check("mid_dv", tx_dv, 0);
      check("mid_ovf", overflow, 0);
      dvs = dv_count;
      wait_frames("mid_frame_end", f0 + 1, 100);
      steps(3);
      check("mid_no_dv", dv_count, dvs);
      wr_dv = 1'b1; wr_byte = 8'h77; step();
      wr_dv = 1'b0; step();
      check("mid_new_dv", tx_dv, 1);
      check("mid_new_byte", tx_byte, 8'h77);
      wait_frames("mid_new_frame", f0 + 2, 100);
      check("mid_sent_n", sent.size(), base_s + 2);
      check("mid_sent_3c", sent[base_s], 8'h3C);
      check("mid_sent_77", sent[base_s + 1], 8'h77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
